// File: rtl/chiplet_pkg.sv
// Shared chiplet types: node/packet ids, packet formats, flit and header layouts,
// length defaults and CRC-32 constants, plus small format/length helpers.
package chiplet_pkg;

  typedef logic [4:0] node_id_t;
  typedef logic [1:0] pkt_id_t;

  typedef enum logic [3:0] {
    FMT_LONG_READ   = 4'h0,
    FMT_LONG_WRITE  = 4'h1,
    FMT_MSG         = 4'h4,
    FMT_SHORT_READ  = 4'h8,
    FMT_SHORT_WRITE = 4'h9
  } format_e;

  typedef struct packed {
    logic     vc;
    pkt_id_t  id;
    node_id_t req;
  } flit_meta_t;

  typedef struct packed {
    flit_meta_t  meta;
    logic [31:0] payload;
  } flit_t;

  typedef struct packed {
    format_e    fmt;
    node_id_t   dest;
    logic [7:0] r0;
    logic [3:0] lst_b;
    logic [3:0] fst_b;
    logic [6:0] len;
  } long_hdr_t;

  typedef struct packed {
    format_e     fmt;
    node_id_t    dest;
    logic [18:0] addr;
    logic [3:0]  len;
  } short_hdr_t;

  localparam logic [7:0]  LONG_LEN_DEFAULT  = 8'd128;
  localparam logic [7:0]  SHORT_LEN_DEFAULT = 8'd16;
  localparam logic [31:0] CRC32_POLY        = 32'h04C11DB7;
  localparam logic [31:0] CRC32_INIT        = 32'hFFFFFFFF;

  function automatic logic fmt_supported(input format_e f);
    logic ok;
    case (f)
      FMT_LONG_READ, FMT_LONG_WRITE, FMT_SHORT_READ, FMT_SHORT_WRITE: ok = 1'b1;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic fmt_is_long(input format_e f);
    logic r;
    case (f)
      FMT_LONG_READ, FMT_LONG_WRITE: r = 1'b1;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic fmt_is_write(input format_e f);
    logic r;
    case (f)
      FMT_LONG_WRITE, FMT_SHORT_WRITE: r = 1'b1;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  // A zero length field encodes the format's maximum word count.
  function automatic logic [7:0] data_words(input format_e f, input logic [6:0] len);
    logic [7:0] n;
    case (f)
      FMT_LONG_WRITE:  n = (len == 7'd0) ? LONG_LEN_DEFAULT : {1'b0, len};
      FMT_SHORT_WRITE: n = (len[3:0] == 4'd0) ? SHORT_LEN_DEFAULT : {4'd0, len[3:0]};
      default:         n = 8'd0;
    endcase
    return n;
  endfunction

  function automatic logic [7:0] expected_num_flits(input logic [31:0] hdr);
    format_e    f;
    logic [7:0] n;
    f = format_e'(hdr[31:28]);
    case (f)
      FMT_LONG_READ:   n = 8'd3;
      FMT_LONG_WRITE:  n = 8'd3 + data_words(f, hdr[6:0]);
      FMT_SHORT_READ:  n = 8'd2;
      FMT_SHORT_WRITE: n = 8'd2 + data_words(f, {3'd0, hdr[3:0]});
      default:         n = 8'd0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/chiplet_crc32_word.sv
// One-word CRC-32 update: MSB-first, unreflected, using the package polynomial.
module chiplet_crc32_word
  import chiplet_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [31:0] data,
  output logic [31:0] crc_out
);

  logic [31:0] w_c;

  // Fold the whole word into the register, then run 32 polynomial shifts.
  always_comb begin
    w_c = crc_in ^ data;
    for (int i = 0; i < 32; i++) begin
      if (w_c[31]) begin
        w_c = {w_c[30:0], 1'b0} ^ CRC32_POLY;
      end else begin
        w_c = {w_c[30:0], 1'b0};
      end
    end
    crc_out = w_c;
  end

endmodule

// File: rtl/pkt_tx_builder.sv
// Packet transmit builder: turns one command into HDR/[ADDR]/[DATA]/CRC flits,
// carrying a running CRC-32 over every accepted payload word.
module pkt_tx_builder
  import chiplet_pkg::*;
(
  input  logic        CLK,
  input  logic        RST,
  input  node_id_t    src_id,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [3:0]  cmd_format,
  input  node_id_t    cmd_dest,
  input  logic [31:0] cmd_addr,
  input  logic [6:0]  cmd_len,
  input  logic [3:0]  cmd_fst_b,
  input  logic [3:0]  cmd_lst_b,
  input  logic        cmd_vc,
  input  pkt_id_t     cmd_id,
  input  logic        wdata_valid,
  output logic        wdata_ready,
  input  logic [31:0] wdata,
  output logic        flit_valid,
  input  logic        flit_ready,
  output flit_t       flit,
  output logic        busy,
  output logic        err_fmt
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HDR  = 3'd1,
    ST_ADDR = 3'd2,
    ST_DATA = 3'd3,
    ST_CRC  = 3'd4
  } state_e;

  state_e      r_state;
  flit_meta_t  r_meta;
  logic [31:0] r_payload;
  logic        r_flit_valid;
  logic [31:0] r_addr;
  logic        r_is_long;
  logic        r_is_write;
  logic [7:0]  r_cnt;
  logic [31:0] r_crc;
  logic        r_err_fmt;

  format_e     w_fmt;
  long_hdr_t   w_long_hdr;
  short_hdr_t  w_short_hdr;
  logic [31:0] w_hdr;
  logic        w_in_data;
  logic [31:0] w_payload;
  logic        w_fire;
  logic        w_accept;
  logic [31:0] w_crc_next;

  // Build both header layouts from the live command fields; the format picks one.
  always_comb begin
    w_fmt             = format_e'(cmd_format);
    w_long_hdr.fmt    = w_fmt;
    w_long_hdr.dest   = cmd_dest;
    w_long_hdr.r0     = 8'd0;
    w_long_hdr.lst_b  = cmd_lst_b;
    w_long_hdr.fst_b  = cmd_fst_b;
    w_long_hdr.len    = cmd_len;
    w_short_hdr.fmt   = w_fmt;
    w_short_hdr.dest  = cmd_dest;
    w_short_hdr.addr  = cmd_addr[20:2];
    w_short_hdr.len   = cmd_len[3:0];
    if (fmt_is_long(w_fmt)) begin
      w_hdr = w_long_hdr;
    end else begin
      w_hdr = w_short_hdr;
    end
  end

  // Write data streams straight through in DATA; every other flit comes from registers.
  assign w_in_data   = (r_state == ST_DATA);
  assign w_payload   = w_in_data ? wdata : r_payload;
  assign flit_valid  = w_in_data ? wdata_valid : r_flit_valid;
  assign wdata_ready = w_in_data ? flit_ready : 1'b0;
  assign flit        = {r_meta, w_payload};
  assign cmd_ready   = (r_state == ST_IDLE);
  assign busy        = (r_state != ST_IDLE);
  assign err_fmt     = r_err_fmt;
  assign w_fire      = flit_valid && flit_ready;
  assign w_accept    = cmd_valid && cmd_ready;

  chiplet_crc32_word u_crc (
    .crc_in  (r_crc),
    .data    (w_payload),
    .crc_out (w_crc_next)
  );

  // Packet sequencer: CRC flit carries the CRC including the word accepted just before it.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state      <= ST_IDLE;
      r_meta       <= '0;
      r_payload    <= 32'd0;
      r_flit_valid <= 1'b0;
      r_addr       <= 32'd0;
      r_is_long    <= 1'b0;
      r_is_write   <= 1'b0;
      r_cnt        <= 8'd0;
      r_crc        <= CRC32_INIT;
      r_err_fmt    <= 1'b0;
    end else begin
      r_err_fmt <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_meta     <= {cmd_vc, cmd_id, src_id};
            r_addr     <= cmd_addr;
            r_is_long  <= fmt_is_long(w_fmt);
            r_is_write <= fmt_is_write(w_fmt);
            r_cnt      <= data_words(w_fmt, cmd_len);
            r_crc      <= CRC32_INIT;
            if (fmt_supported(w_fmt)) begin
              r_state      <= ST_HDR;
              r_payload    <= w_hdr;
              r_flit_valid <= 1'b1;
            end else begin
              r_err_fmt <= 1'b1;
            end
          end
        end
        ST_HDR: begin
          if (w_fire) begin
            r_crc <= w_crc_next;
            if (r_is_long) begin
              r_state   <= ST_ADDR;
              r_payload <= r_addr;
            end else if (r_is_write) begin
              r_state      <= ST_DATA;
              r_flit_valid <= 1'b0;
            end else begin
              r_state   <= ST_CRC;
              r_payload <= w_crc_next;
            end
          end
        end
        ST_ADDR: begin
          if (w_fire) begin
            r_crc <= w_crc_next;
            if (r_is_write) begin
              r_state      <= ST_DATA;
              r_flit_valid <= 1'b0;
            end else begin
              r_state   <= ST_CRC;
              r_payload <= w_crc_next;
            end
          end
        end
        ST_DATA: begin
          if (w_fire) begin
            r_crc <= w_crc_next;
            r_cnt <= r_cnt - 8'd1;
            if (r_cnt == 8'd1) begin
              r_state      <= ST_CRC;
              r_payload    <= w_crc_next;
              r_flit_valid <= 1'b1;
            end
          end
        end
        ST_CRC: begin
          if (w_fire) begin
            r_state      <= ST_IDLE;
            r_payload    <= 32'd0;
            r_flit_valid <= 1'b0;
            r_crc        <= CRC32_INIT;
          end
        end
        default: begin
          r_state      <= ST_IDLE;
          r_flit_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pkt_tx_builder.sv
// Directed bench for pkt_tx_builder: reference header/CRC/length model,
// per-flit payload and metadata checks, stall stability, error and reset cases.
module tb_pkt_tx_builder;

  localparam logic [3:0] F_LR  = 4'h0;
  localparam logic [3:0] F_LW  = 4'h1;
  localparam logic [3:0] F_MSG = 4'h4;
  localparam logic [3:0] F_SR  = 4'h8;
  localparam logic [3:0] F_SW  = 4'h9;

  logic        CLK = 1'b0;
  logic        RST;
  logic [4:0]  src_id;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [3:0]  cmd_format;
  logic [4:0]  cmd_dest;
  logic [31:0] cmd_addr;
  logic [6:0]  cmd_len;
  logic [3:0]  cmd_fst_b;
  logic [3:0]  cmd_lst_b;
  logic        cmd_vc;
  logic [1:0]  cmd_id;
  logic        wdata_valid;
  logic        wdata_ready;
  logic [31:0] wdata;
  logic        flit_valid;
  logic        flit_ready;
  logic [39:0] flit;
  logic        busy;
  logic        err_fmt;

  int n_cmp = 0;
  int n_err = 0;
  logic [39:0] q_flit[$];

  always #5 CLK = ~CLK;

  pkt_tx_builder dut (
    .CLK(CLK), .RST(RST), .src_id(src_id),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_format(cmd_format),
    .cmd_dest(cmd_dest), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .cmd_fst_b(cmd_fst_b), .cmd_lst_b(cmd_lst_b), .cmd_vc(cmd_vc), .cmd_id(cmd_id),
    .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .wdata(wdata),
    .flit_valid(flit_valid), .flit_ready(flit_ready), .flit(flit),
    .busy(busy), .err_fmt(err_fmt)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] m_crc(input logic [31:0] c, input logic [31:0] d);
    logic [31:0] r;
    logic        fb;
    r = c;
    for (int i = 31; i >= 0; i--) begin
      fb = r[31] ^ d[i];
      r  = {r[30:0], 1'b0};
      if (fb) r = r ^ 32'h04C11DB7;
    end
    return r;
  endfunction

  function automatic logic [31:0] m_hdr(input logic [3:0] f, input logic [4:0] d,
                                        input logic [31:0] a, input logic [6:0] l,
                                        input logic [3:0] fb, input logic [3:0] lb);
    if (f == F_LR || f == F_LW) return {f, d, 8'h00, lb, fb, l};
    else return {f, d, a[20:2], l[3:0]};
  endfunction

  function automatic int m_ndata(input logic [3:0] f, input logic [6:0] l);
    if (f == F_LW) return (l == 7'd0) ? 128 : int'(l);
    else if (f == F_SW) return (l[3:0] == 4'd0) ? 16 : int'(l[3:0]);
    else return 0;
  endfunction

  function automatic int m_nflits(input logic [3:0] f, input logic [6:0] l);
    return ((f == F_LR || f == F_LW) ? 3 : 2) + m_ndata(f, l);
  endfunction

  // Issue one command and collect its flits; checks latency, stalls, payloads, meta.
  task automatic run_pkt(input logic [3:0] fmt, input logic [4:0] dest, input logic [31:0] addr,
                         input logic [6:0] len, input logic [3:0] fst, input logic [3:0] lst,
                         input logic vc, input logic [1:0] id, input bit stall,
                         input logic [31:0] dbase);
    int          exp_n, nd, cyc, sent;
    logic [31:0] exp_pl[$];
    logic [31:0] c;
    logic [39:0] prev;
    bit          prev_stall, hold_wv;
    q_flit.delete();
    exp_n = m_nflits(fmt, len);
    nd    = m_ndata(fmt, len);
    cyc   = 0;
    while (!cmd_ready && cyc < 50) begin
      @(posedge CLK); #1; cyc++;
    end
    chk("cmd_ready_before_cmd", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_format = fmt; cmd_dest = dest; cmd_addr = addr; cmd_len = len;
    cmd_fst_b = fst; cmd_lst_b = lst; cmd_vc = vc; cmd_id = id;
    @(posedge CLK); #1;
    cmd_valid = 1'b0;
    chk("hdr_valid_latency", flit_valid, 1);
    sent = 0; prev_stall = 0; hold_wv = 0; cyc = 0; prev = '0;
    while (q_flit.size() < exp_n && cyc < 3000) begin
      flit_ready  = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      wdata_valid = hold_wv ? 1'b1 : (stall ? 1'($urandom_range(0, 1)) : 1'b1);
      wdata       = dbase + 32'(sent);
      @(negedge CLK);
      if (prev_stall) begin
        chk("stall_valid_held", flit_valid, 1);
        chk("stall_flit_held", flit, prev);
      end
      hold_wv    = wdata_valid && !wdata_ready;
      prev_stall = flit_valid && !flit_ready;
      prev       = flit;
      if (flit_valid && flit_ready) q_flit.push_back(flit);
      if (wdata_valid && wdata_ready) sent++;
      @(posedge CLK); #1; cyc++;
    end
    wdata_valid = 1'b0;
    chk("flit_count", q_flit.size(), exp_n);
    chk("data_words_taken", sent, nd);
    chk("idle_gap_valid", flit_valid, 0);
    chk("idle_gap_busy", busy, 0);
    chk("idle_gap_cmd_ready", cmd_ready, 1);
    exp_pl.push_back(m_hdr(fmt, dest, addr, len, fst, lst));
    if (fmt == F_LR || fmt == F_LW) exp_pl.push_back(addr);
    for (int k = 0; k < nd; k++) exp_pl.push_back(dbase + 32'(k));
    c = 32'hFFFFFFFF;
    foreach (exp_pl[k]) c = m_crc(c, exp_pl[k]);
    exp_pl.push_back(c);
    for (int i = 0; i < exp_n; i++) begin
      if (i < q_flit.size())
        chk($sformatf("flit%0d_f%0h_l%0d", i, fmt, len), q_flit[i], {vc, id, src_id, exp_pl[i]});
    end
  endtask

  initial begin
    int cyc;
    RST = 1'b1; src_id = 5'h0B; cmd_valid = 1'b0; cmd_format = 4'h0; cmd_dest = 5'd0;
    cmd_addr = 32'd0; cmd_len = 7'd0; cmd_fst_b = 4'h0; cmd_lst_b = 4'h0; cmd_vc = 1'b0;
    cmd_id = 2'd0; wdata_valid = 1'b0; wdata = 32'd0; flit_ready = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_flit_valid", flit_valid, 0);
    chk("rst_flit", flit, 40'd0);
    chk("rst_wdata_ready", wdata_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err_fmt", err_fmt, 0);
    RST = 1'b0;
    @(posedge CLK); #1;
    chk("rst_cmd_ready", cmd_ready, 1);

    run_pkt(F_SR, 5'd5, 32'h0000_0040, 7'd0, 4'h0, 4'h0, 1'b1, 2'd2, 1'b0, 32'h0);
    chk("short_read_hdr", q_flit[0][31:0], 32'h82800100);
    chk("short_read_n", q_flit.size(), 2);

    run_pkt(F_LW, 5'd3, 32'h1000_0008, 7'd4, 4'hF, 4'hF, 1'b0, 2'd1, 1'b0, 32'hD000_0000);
    chk("long_write_hdr", q_flit[0][31:0], 32'h11807F84);
    chk("long_write_n", q_flit.size(), 7);

    run_pkt(F_LR, 5'd7, 32'hDEAD_BEE0, 7'd9, 4'h3, 4'hC, 1'b1, 2'd3, 1'b0, 32'h0);
    chk("long_read_n", q_flit.size(), 3);

    run_pkt(F_LW, 5'd1, 32'h0000_1000, 7'd0, 4'h1, 4'h8, 1'b1, 2'd0, 1'b1, 32'h5A00_0000);
    chk("long_write_max_n", q_flit.size(), 131);

    run_pkt(F_SW, 5'd2, 32'h0000_0100, 7'd0, 4'h0, 4'h0, 1'b0, 2'd2, 1'b0, 32'h1100_0000);
    chk("short_write_max_n", q_flit.size(), 18);
    run_pkt(F_SW, 5'd9, 32'h001F_FFFC, 7'h35, 4'h0, 4'h0, 1'b1, 2'd1, 1'b1, 32'h2200_0000);
    chk("short_write_len_upper_ignored_n", q_flit.size(), 7);
    for (int l = 1; l < 16; l++) begin
      run_pkt(F_SW, 5'(l), 32'(l) << 4, 7'(l), 4'h0, 4'h0, 1'b0, 2'(l), 1'b0, 32'(l) << 24);
      run_pkt(F_SR, 5'(l), 32'(l) << 6, 7'(l), 4'h0, 4'h0, 1'b1, 2'(l), 1'b0, 32'h0);
    end

    cmd_format = F_MSG; cmd_valid = 1'b1;
    @(posedge CLK); #1;
    cmd_valid = 1'b0;
    chk("err_fmt_pulse", err_fmt, 1);
    chk("err_no_flit", flit_valid, 0);
    chk("err_cmd_ready", cmd_ready, 1);
    @(posedge CLK); #1;
    chk("err_fmt_one_cycle", err_fmt, 0);
    chk("err_still_no_flit", flit_valid, 0);

    cmd_format = F_LW; cmd_dest = 5'd4; cmd_addr = 32'h0000_0200; cmd_len = 7'd8;
    cmd_valid = 1'b1;
    @(posedge CLK); #1;
    cmd_valid = 1'b0; flit_ready = 1'b1; wdata_valid = 1'b1; wdata = 32'hCAFE_0000;
    cyc = 0;
    while (!wdata_ready && cyc < 20) begin
      @(posedge CLK); #1; cyc++;
    end
    chk("reached_data_phase", wdata_ready, 1);
    @(posedge CLK); #1;
    RST = 1'b1;
    #1;
    chk("midrst_flit_valid", flit_valid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_wdata_ready", wdata_ready, 0);
    @(posedge CLK); #1;
    RST = 1'b0; wdata_valid = 1'b0;
    @(posedge CLK); #1;
    chk("midrst_no_flit", flit_valid, 0);
    run_pkt(F_SR, 5'd6, 32'h0000_0080, 7'd0, 4'h0, 4'h0, 1'b0, 2'd1, 1'b0, 32'h0);
    chk("after_rst_short_read_n", q_flit.size(), 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
